// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store unit: data width, access sizes, FSM states
// and the address-alignment rules used by both the datapath and the trap logic.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] SIZE_BYTE     = 2'b00;
   localparam logic [1:0] SIZE_HALF     = 2'b01;
   localparam logic [1:0] SIZE_WORD     = 2'b10;
   localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } lsu_state_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = lo[0];
         default:   is_misaligned = (lo != 2'b00);
      endcase
   endfunction

   // Drops the low address bits an access of this size cannot legally use.
   function automatic logic [1:0] clean_lo(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SIZE_BYTE: clean_lo = lo;
         SIZE_HALF: clean_lo = {lo[1], 1'b0};
         default:   clean_lo = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes and replicated write data from the live
// request, and extracted/extended load data from the latched request.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [1:0]      st_size,
   input  logic [1:0]      st_lo,
   input  logic [XLEN-1:0] store_data,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata,
   input  logic [1:0]      ld_size,
   input  logic [1:0]      ld_lo,
   input  logic            ld_unsigned,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [7:0]  lanes [4];
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
   end

   always_comb begin
      wstrb = 4'b1111;
      wdata = store_data;
      case (st_size)
         SIZE_BYTE: begin
            wstrb = 4'b0001 << st_lo;
            wdata = {4{store_data[7:0]}};
         end
         SIZE_HALF: begin
            wstrb = 4'b0011 << {st_lo[1], 1'b0};
            wdata = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = lanes[ld_lo];
      ld_half = ld_lo[1] ? rdata[31:16] : rdata[15:0];
      ld_data = rdata;
      case (ld_size)
         SIZE_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         SIZE_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the core pipeline to a req/gnt/rvalid
// data bus. Define MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating.
module load_store_unit
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_valid,
   input  logic            op_load,
   input  logic [1:0]      op_size,
   input  logic            op_unsigned,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   input  logic [4:0]      rd,
   output logic            stall,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
`ifdef MISALIGN_TRAP_EN
   ,
   output logic            misalign
`endif
);

   lsu_state_t      state_reg;
   logic            op_load_reg;
   logic            op_unsigned_reg;
   logic [1:0]      op_size_reg;
   logic [1:0]      addr_lo_reg;
   logic [4:0]      rd_reg;
   logic            mem_req_reg;
   logic            mem_we_reg;
   logic [XLEN-1:0] mem_addr_reg;
   logic [XLEN-1:0] mem_wdata_reg;
   logic [3:0]      mem_wstrb_reg;
   logic            wb_valid_reg;
   logic [4:0]      wb_rd_reg;
   logic [XLEN-1:0] wb_data_reg;

   logic [1:0]      eff_lo;
   logic [3:0]      st_wstrb;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] ld_data;
   logic            trap;

   assign eff_lo = clean_lo(op_size, addr[1:0]);

`ifdef MISALIGN_TRAP_EN
   logic misalign_reg;
   assign trap     = is_misaligned(op_size, addr[1:0]);
   assign misalign = misalign_reg;
`else
   assign trap = 1'b0;
`endif

   lsu_align u_align (
      .st_size     (op_size),
      .st_lo       (eff_lo),
      .store_data  (store_data),
      .wstrb       (st_wstrb),
      .wdata       (st_wdata),
      .ld_size     (op_size_reg),
      .ld_lo       (addr_lo_reg),
      .ld_unsigned (op_unsigned_reg),
      .rdata       (mem_rdata),
      .ld_data     (ld_data)
   );

   // rst_n gates the IDLE term so stall reads 0 while reset is held.
   assign stall = (state_reg == IDLE && op_valid && rst_n) ||
                  (state_reg == REQ) || (state_reg == WAIT);

   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_wstrb = mem_wstrb_reg;
   assign wb_valid  = wb_valid_reg;
   assign wb_rd     = wb_rd_reg;
   assign wb_data   = wb_data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         op_load_reg     <= 1'b0;
         op_unsigned_reg <= 1'b0;
         op_size_reg     <= SIZE_BYTE;
         addr_lo_reg     <= 2'b00;
         rd_reg          <= 5'd0;
         mem_req_reg     <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         mem_wstrb_reg   <= 4'b0000;
         wb_valid_reg    <= 1'b0;
         wb_rd_reg       <= 5'd0;
         wb_data_reg     <= '0;
`ifdef MISALIGN_TRAP_EN
         misalign_reg    <= 1'b0;
`endif
      end else begin
         wb_valid_reg <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (op_valid) begin
                  op_load_reg     <= op_load;
                  op_unsigned_reg <= op_unsigned;
                  op_size_reg     <= op_size;
                  addr_lo_reg     <= eff_lo;
                  rd_reg          <= rd;
                  mem_addr_reg    <= {addr[XLEN-1:2], 2'b00};
                  mem_wdata_reg   <= st_wdata;
                  mem_wstrb_reg   <= st_wstrb;
                  if (trap) begin
                     state_reg    <= DONE;
`ifdef MISALIGN_TRAP_EN
                     misalign_reg <= 1'b1;
`endif
                  end else begin
                     state_reg   <= REQ;
                     mem_req_reg <= 1'b1;
                     mem_we_reg  <= ~op_load;
                  end
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  state_reg   <= op_load_reg ? WAIT : DONE;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state_reg    <= DONE;
                  wb_data_reg  <= ld_data;
                  wb_rd_reg    <= rd_reg;
                  wb_valid_reg <= (rd_reg != 5'd0);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec scenarios plus randomized
// loads/stores with random bus latencies, checked against an arithmetic lane model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_load = 1'b0;
   logic [1:0]  op_size = 2'b00;
   logic        op_unsigned = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  rd = '0;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   load_store_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op_valid    (op_valid),
      .op_load     (op_load),
      .op_size     (op_size),
      .op_unsigned (op_unsigned),
      .addr        (addr),
      .store_data  (store_data),
      .rd          (rd),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata)
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign    (misalign)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference model: accesses are described as (byte offset, byte count).
   function automatic int m_nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic int m_offset(input logic [1:0] sz, input logic [31:0] a);
      int n;
      n = m_nbytes(sz);
      return ((a % 4) / n) * n;
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [1:0] sz, input logic [31:0] a);
      int n;
      n = m_nbytes(sz);
      return 4'(((1 << n) - 1) << m_offset(sz, a));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
      if (sz == 2'b00) return (sd & 32'hFF) * 32'h01010101;
      if (sz == 2'b01) return (sd & 32'hFFFF) * 32'h00010001;
      return sd;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] a, input logic [31:0] rdata);
      int          n;
      logic [31:0] mask;
      logic [31:0] v;
      n = m_nbytes(sz);
      if (n == 4) return rdata;
      mask = (32'h1 << (8 * n)) - 1;
      v = (rdata >> (8 * m_offset(sz, a))) & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // One complete transaction with programmable grant and read-data latency.
   task automatic run_op(input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                         input int gdly, input int rdly, input logic [31:0] rdata);
      logic [31:0] exp_addr;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wd;
      logic [31:0] exp_ld;
      logic        exp_wb;
      int          stall_cnt;
      int          exp_stall;
      exp_addr  = {a[31:2], 2'b00};
      exp_strb  = m_wstrb(sz, a);
      exp_wd    = m_wdata(sz, sd);
      exp_ld    = m_load(sz, uns, a, rdata);
      exp_wb    = ld && (r != 5'd0);
      exp_stall = 1 + (gdly + 1) + (ld ? rdly + 1 : 0);
      stall_cnt = 0;

      @(negedge clk);
      op_valid = 1'b1; op_load = ld; op_size = sz; op_unsigned = uns;
      addr = a; store_data = sd; rd = r;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL idle_stall: stall=%b required 1", stall);
      end
      if (stall === 1'b1) stall_cnt++;
      @(negedge clk);
      op_valid = 1'b0;
      addr = $urandom; store_data = $urandom; rd = 5'($urandom); op_load = ~ld;

      for (int i = 0; i <= gdly; i++) begin
         tests_run++;
         if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== !ld) begin
            tests_failed++;
            $display("FAIL req_fields cyc%0d: req=%b addr=%h we=%b required req=1 addr=%h we=%b",
                     i, mem_req, mem_addr, mem_we, exp_addr, !ld);
         end
         if (!ld) begin
            tests_run++;
            if (mem_wstrb !== exp_strb || mem_wdata !== exp_wd) begin
               tests_failed++;
               $display("FAIL store_lanes cyc%0d: wstrb=%b wdata=%h required wstrb=%b wdata=%h",
                        i, mem_wstrb, mem_wdata, exp_strb, exp_wd);
            end
         end
         if (stall === 1'b1) stall_cnt++;
         if (i == gdly) mem_gnt = 1'b1;
         @(negedge clk);
         mem_gnt = 1'b0;
      end

      if (ld) begin
         for (int j = 0; j <= rdly; j++) begin
            tests_run++;
            if (mem_req !== 1'b0) begin
               tests_failed++;
               $display("FAIL wait_req cyc%0d: mem_req=%b required 0", j, mem_req);
            end
            if (stall === 1'b1) stall_cnt++;
            if (j == rdly) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rdata;
            end else begin
               mem_rdata  = $urandom;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
         end
      end

      tests_run++;
      if (stall !== 1'b0 || wb_valid !== exp_wb || mem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_ctrl: stall=%b wb_valid=%b req=%b required stall=0 wb_valid=%b req=0",
                  stall, wb_valid, mem_req, exp_wb);
      end
      if (exp_wb) begin
         tests_run++;
         if (wb_rd !== r || wb_data !== exp_ld) begin
            tests_failed++;
            $display("FAIL wb_result: rd=%0d data=%h required rd=%0d data=%h",
                     wb_rd, wb_data, r, exp_ld);
         end
      end
      tests_run++;
      if (stall_cnt != exp_stall) begin
         tests_failed++;
         $display("FAIL stall_cycles: got %0d required %0d", stall_cnt, exp_stall);
      end
      @(negedge clk);
      tests_run++;
      if (wb_valid !== 1'b0 || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL wb_pulse: wb_valid=%b stall=%b one cycle after DONE, required 0/0",
                  wb_valid, stall);
      end
      $display("[TB] %s size=%0d uns=%0d addr=%h sd=%h rd=%0d gnt_dly=%0d rv_dly=%0d wb_exp=%h",
               ld ? "load " : "store", sz, uns, a, sd, r, gdly, rdly, exp_ld);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      op_valid = 1'b1;
      #17;
      tests_run++;
      if ({stall, wb_valid, wb_rd, wb_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: stall=%b wbv=%b req=%b we=%b addr=%h wd=%h strb=%b required all 0",
                  stall, wb_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] reset released");
   endtask

   task automatic test_store_word();
      run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0);
   endtask

   task automatic test_load_byte();
      run_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80112233);
      run_op(1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80112233);
   endtask

   task automatic test_store_half_delayed();
      run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 5'd0, 3, 0, 32'h0);
   endtask

   task automatic test_load_rd0();
      run_op(1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 5'd0, 1, 2, 32'h12345678);
   endtask

   task automatic test_stray_rvalid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         @(negedge clk);
         mem_rvalid = 1'b0;
         tests_run++;
         if (wb_valid !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_rvalid: wb_valid=%b stall=%b req=%b required 0/0/0",
                     wb_valid, stall, mem_req);
         end
      end
      $display("[TB] stray rvalid in IDLE ignored check done");
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      op_valid = 1'b1; op_load = 1'b1; op_size = 2'b10; op_unsigned = 1'b0;
      addr = 32'h300; rd = 5'd7;
      @(negedge clk);
      op_valid = 1'b0;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      tests_run++;
      if (stall !== 1'b1 || mem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL pre_reset_wait: stall=%b req=%b required 1/0", stall, mem_req);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({stall, wb_valid, wb_rd, wb_data, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: stall=%b wbv=%b req=%b addr=%h required all 0",
                  stall, wb_valid, mem_req, mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (wb_valid !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_rvalid cyc%0d: wb_valid=%b stall=%b req=%b required 0/0/0",
                     i, wb_valid, stall, mem_req);
         end
         @(negedge clk);
      end
      $display("[TB] reset in WAIT then late rvalid");
      run_op(1'b0, 2'b00, 1'b0, 32'h305, 32'h000000A5, 5'd0, 0, 0, 32'h0);
   endtask

   task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
      @(negedge clk);
      op_valid = 1'b1; op_load = 1'b1; op_size = 2'b10; op_unsigned = 1'b0;
      addr = 32'h102; rd = 5'd9;
      #1;
      tests_run++;
      if (mem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL trap_idle_req: mem_req=%b required 0", mem_req);
      end
      @(negedge clk);
      op_valid = 1'b0;
      tests_run++;
      if (misalign !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL trap_done: misalign=%b req=%b wbv=%b stall=%b required 1/0/0/0",
                  misalign, mem_req, wb_valid, stall);
      end
      @(negedge clk);
      tests_run++;
      if (misalign !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL trap_after: misalign=%b req=%b wbv=%b required 0/0/0",
                  misalign, mem_req, wb_valid);
      end
      $display("[TB] misaligned word load at 0x102 trapped");
`else
      run_op(1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd9, 0, 1, 32'h0BADF00D);
      run_op(1'b0, 2'b01, 1'b0, 32'h203, 32'h00001234, 5'd0, 1, 0, 32'h0);
`endif
   endtask

   task automatic test_random();
      logic        ld;
      logic [1:0]  sz;
      logic [31:0] a;
      for (int k = 0; k < 40; k++) begin
         ld = 1'($urandom);
         sz = 2'($urandom);
         a  = $urandom;
`ifdef MISALIGN_TRAP_EN
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz[1]) a[1:0] = 2'b00;
`endif
         run_op(ld, sz, 1'($urandom), a, $urandom, 5'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_byte();
      test_store_half_delayed();
      test_load_rd0();
      test_stray_rvalid();
      test_reset_mid_wait();
      test_misalign();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have these ports: clk  in  1  core clock, all state on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 op_valid in 1 memory instruction present; op_load in 1 (1=load, 0=store); op_size in 2 (00 byte, 01 half, 10 word, 11 treated as word); op_unsigned in 1 zero-extend loads; addr in 32 ALU effective address; store_data in 32 rs2 value; rd in 5 load destination.
REQ-004 stall out 1 holds PC/fetch while the unit is busy.
REQ-005 wb_valid out 1, wb_rd out 5, wb_data out 32: drive the register file reg_write, rd and write_data.
REQ-006 mem_req out 1, mem_we out 1, mem_addr out 32 (bits[1:0]=0), mem_wdata out 32, mem_wstrb out 4, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32: data-bus port.
REQ-007 misalign out 1: one-cycle fault pulse, present only with MISALIGN_TRAP_EN.

Function
REQ-008 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-009 In IDLE, op_valid=1 SHALL latch op_load, op_size, op_unsigned, addr, store_data and rd, then move to REQ next cycle.
REQ-010 stall SHALL equal (IDLE and op_valid) or state in {REQ, WAIT}; it SHALL be 0 in DONE.
REQ-011 In REQ, mem_req=1, with mem_addr/mem_we/mem_wdata/mem_wstrb held stable until mem_gnt=1.
REQ-012 On mem_gnt in REQ: a store goes to DONE; a load goes to WAIT.
REQ-013 In WAIT, mem_rvalid=1 SHALL capture the extracted, extended load data and go to DONE; mem_rvalid outside WAIT SHALL be ignored.
REQ-014 DONE SHALL last exactly one cycle, then return to IDLE; op_valid is not sampled in DONE.
REQ-015 wb_valid SHALL pulse for one cycle in DONE for a load with rd!=0; it SHALL stay 0 for stores and for rd=0.
REQ-016 Minimum latency with zero-wait memory SHALL be: store 3 cycles (IDLE, REQ, DONE); load 4 cycles (IDLE, REQ, WAIT, DONE).
REQ-017 Store strobes: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-018 Store data: byte {4{sd[7:0]}}; half {2{sd[15:0]}}; word sd.
REQ-019 Load extraction: select the byte/half lane by addr[1:0]; sign-extend unless op_unsigned; a word passes through unchanged.
REQ-020 mem_addr SHALL be {addr[31:2],2'b00}.

Reset
REQ-021 rst_n low SHALL immediately force IDLE and drive stall, wb_valid, wb_rd, wb_data, mem_req, mem_we, mem_wdata, mem_wstrb, mem_addr and misalign to 0, including mid-transaction.
REQ-022 A mem_rvalid arriving after reset for an aborted load SHALL produce no writeback.

Configuration
REQ-023 With MISALIGN_TRAP_EN defined: a half with addr[0]=1, or a word with addr[1:0]!=0, SHALL skip REQ/WAIT and go IDLE->DONE; misalign pulses in DONE; no bus request and no writeback occur.
REQ-024 Without MISALIGN_TRAP_EN: the misalign port SHALL be absent, and offending low address bits SHALL be cleared (half addr[0]; word addr[1:0]) before use.

Structure
REQ-025 Package riscv_pkg SHALL hold the op_size encodings, the LSU state enum and the XLEN=32 constant.
REQ-026 Sub-module lsu_align SHALL be purely combinational and produce strobes, replicated store data and extended load data.

Verification
REQ-027 Store word at 0x100, data 0xDEADBEEF, mem_gnt in the first REQ cycle -> mem_wstrb=1111, mem_wdata=0xDEADBEEF, stall high for 2 cycles, wb_valid=0.
REQ-028 Load byte signed at 0x103, rd=5, mem_rdata=0x80112233 -> wb_data=0xFFFFFF80 and wb_rd=5 for one cycle; the unsigned variant gives 0x00000080.
REQ-029 Store half at 0x102, data 0x0000ABCD, mem_gnt delayed 3 cycles -> mem_wstrb=1100, mem_wdata=0xABCDABCD, request fields stable across all waits.
REQ-030 Load word with rd=0 -> full handshake completes, wb_valid stays 0.
REQ-031 rst_n asserted in WAIT, then mem_rvalid pulsed -> outputs 0, state IDLE, no wb_valid.
REQ-032 Word load at 0x102: with MISALIGN_TRAP_EN -> misalign=1, mem_req never asserted; without it -> mem_addr=0x100, normal load.
